pc_alu_unit: RTL and testbench
==============================

Name: pc_alu_unit

Overview:
- Execute/fetch arithmetic slice of the single-cycle RV32I core.
- Holds the program-counter register (flopr function) and the two address adders: PC+4 and PC+imm (adder function).
- Contains the integer ALU (alu function) with a zero flag for branch decisions.
- Sits between the next-PC muxing and the register file/operand muxes in the datapath.

Parameters:
- WIDTH, 32, datapath and PC width in bits.
- RESET_PC, 32'h0000_0000, value loaded into the PC while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pcnext  input  WIDTH  next PC, selected externally; captured every clock.
- imm  input  WIDTH  sign-extended immediate for the branch target.
- pc  output  WIDTH  current PC (registered).
- pcplus4  output  WIDTH  pc + 4.
- pcbranch  output  WIDTH  pc + imm.
- a  input  WIDTH  ALU operand A.
- b  input  WIDTH  ALU operand B.
- aluctr  input  4  ALU operation select.
- aluout  output  WIDTH  ALU result.
- iszero  output  1  high when aluout == 0.

Behaviour:
- PC register:
  - reset low → pc = RESET_PC immediately, independent of clk.
  - While reset is low, pc holds RESET_PC.
  - reset high → pc <= pcnext on each rising clk edge; no enable, no stall.
  - Reset release coincident with a clock edge: the edge is ignored; the first load occurs on the following edge.
- Adders: purely combinational, modulo 2^WIDTH; wrap-around silently, no carry out.
  - pcplus4 = pc + 4. Example: 32'hFFFF_FFFC + 4 = 0.
  - pcbranch = pc + imm, two's complement, so a negative imm moves backwards.
- ALU: purely combinational, zero latency. aluctr encoding is {funct7[5], funct3}:
  - 0000 ADD a+b (wrap).
  - 1000 SUB a-b (wrap).
  - 0001 SLL a << b[4:0].
  - 0010 SLT: 1 if signed(a) < signed(b), else 0 (zero-extended).
  - 0011 SLTU: unsigned compare, same result format as SLT.
  - 0100 XOR.
  - 0101 SRL: logical shift right by b[4:0].
  - 1101 SRA: arithmetic shift right by b[4:0].
  - 0110 OR.
  - 0111 AND.
  - 1001 PASSB: aluout = b (LUI).
  - All other codes: aluout = 0.
- Shift amounts use only b[4:0]; upper bits of b are ignored.
- iszero = (aluout == 0) for every opcode, including undefined codes (undefined code → iszero = 1).
- No state other than the PC; ALU and adders do not depend on reset.

Decomposition:
- Shared package riscv_pkg holds the 4-bit ALU opcode constants and XLEN = 32.
- One sub-module is natural: alu_core (operation decode + zero flag).
- PC register and adders stay inline.

Test Plan:
- Reset: reset=0 mid-cycle with pcnext=32'h40 → pc = 0 immediately, without waiting for a clk edge. Release reset, then next edge → pc = 32'h40, pcplus4 = 32'h44.
- Sequencing and wrap: pcnext = pcplus4 for 3 edges from 0 → pc = 4, 8, 12. Force pc = 32'hFFFF_FFFC → pcplus4 = 0. imm = 32'hFFFF_FFF8 with pc = 32'h10 → pcbranch = 32'h8.
- Arithmetic: ADD 32'h7FFF_FFFF + 1 = 32'h8000_0000. SUB 5-5 = 0 with iszero = 1. SUB 3-5 = 32'hFFFF_FFFE with iszero = 0.
- Compares: SLT a = -1, b = 1 → 1. SLTU a = 32'hFFFF_FFFF, b = 1 → 0. SLT a = b → 0 with iszero = 1.
- Shifts/logic: SLL 1 by b = 32'h21 → 2 (only b[4:0] = 1 used). SRL 32'h8000_0000 by 31 → 1. SRA 32'h8000_0000 by 31 → 32'hFFFF_FFFF. AND/OR/XOR of 32'hF0F0_F0F0 and 32'hFF00_FF00 → 32'hF000_F000 / 32'hFFF0_FFF0 / 32'h0FF0_0FF0.
- PASSB with b = 32'h1234_5000 → aluout = 32'h1234_5000. Undefined code 1111 → aluout = 0, iszero = 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width and the {funct7[5], funct3} ALU opcodes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/pc_alu_unit_if.sv
// Datapath bundle between the next-PC/operand muxes and the PC/ALU slice.
interface pc_alu_unit_if
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) ();

  logic [WIDTH-1:0] pcnext;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcplus4;
  logic [WIDTH-1:0] pcbranch;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluctr;
  logic [WIDTH-1:0] aluout;
  logic             iszero;

  modport master (
    output pcnext, imm, a, b, aluctr,
    input  pc, pcplus4, pcbranch, aluout, iszero
  );

  modport slave (
    input  pcnext, imm, a, b, aluctr,
    output pc, pcplus4, pcbranch, aluout, iszero
  );

endinterface

// File: rtl/pc_alu_unit_alu_core.sv
// Combinational integer ALU with zero flag; shifts use only the low log2(WIDTH) bits of b.
module alu_core
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       aluctr_i,
  output logic [WIDTH-1:0] aluout_c_o,
  output logic             iszero_c_o
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;

  assign shamt = b_i[SHAMT_W-1:0];

  // Undefined opcodes fall through to zero, which also raises the zero flag.
  always_comb begin
    result = '0;
    case (alu_op_e'(aluctr_i))
      ALU_ADD:   result = a_i + b_i;
      ALU_SUB:   result = a_i - b_i;
      ALU_SLL:   result = a_i << shamt;
      ALU_SLT:   result = WIDTH'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  result = WIDTH'(a_i < b_i);
      ALU_XOR:   result = a_i ^ b_i;
      ALU_SRL:   result = a_i >> shamt;
      ALU_SRA:   result = WIDTH'($signed(a_i) >>> shamt);
      ALU_OR:    result = a_i | b_i;
      ALU_AND:   result = a_i & b_i;
      ALU_PASSB: result = b_i;
      default:   result = '0;
    endcase
  end

  assign aluout_c_o = result;
  assign iszero_c_o = (result == '0);

endmodule

// File: rtl/pc_alu_unit.sv
// Execute/fetch arithmetic slice: PC register, PC+4 and PC+imm adders, integer ALU.
module pc_alu_unit
  import riscv_pkg::*;
#(
  parameter int unsigned    WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  pc_alu_unit_if.slave  bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  assign pc_d = bus.pcnext;

  // PC loads unconditionally every edge; reset forces RESET_PC asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pcplus4  = pc_q + WIDTH'(4);
  assign bus.pcbranch = pc_q + bus.imm;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i        (bus.a),
    .b_i        (bus.b),
    .aluctr_i   (bus.aluctr),
    .aluout_c_o (bus.aluout),
    .iszero_c_o (bus.iszero)
  );

endmodule

// File: tb/tb_pc_alu_unit.sv
// Self-checking bench for pc_alu_unit: directed corner cases plus randomized traffic against a reference model.
module tb_pc_alu_unit;
  import riscv_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;
  logic [31:0] exp_pc = 32'h0;

  pc_alu_unit_if #(.WIDTH(W)) bus ();

  pc_alu_unit #(
    .WIDTH    (W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU computed with wide integer arithmetic rather than bit operators.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, p2, r;
    int     sa, sb;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = int'(a);
    sb = int'(b);
    p2 = longint'(1) << b[4:0];
    case (op)
      4'b0000: r = ua + ub;
      4'b1000: r = ua - ub;
      4'b0001: r = ua * p2;
      4'b0010: r = (sa < sb) ? 1 : 0;
      4'b0011: r = (ua < ub) ? 1 : 0;
      4'b0100: r = longint'({32'h0, a ^ b});
      4'b0101: r = ua / p2;
      4'b1101: r = a[31] ? ~((longint'({32'h0, ~a})) / p2) : ua / p2;
      4'b0110: r = longint'({32'h0, a | b});
      4'b0111: r = longint'({32'h0, a & b});
      4'b1001: r = ub;
      default: r = 0;
    endcase
    return 32'(r);
  endfunction

  // PC model: last sampled pcnext, or the reset vector while reset is low.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_pc = 32'h0;
    else        exp_pc = bus.pcnext;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] ea;
      ea = ref_alu(bus.aluctr, bus.a, bus.b);
      check("cyc_pc",       bus.pc,       exp_pc);
      check("cyc_pcplus4",  bus.pcplus4,  exp_pc + 32'd4);
      check("cyc_pcbranch", bus.pcbranch, exp_pc + bus.imm);
      check("cyc_aluout",   bus.aluout,   ea);
      check("cyc_iszero",   32'(bus.iszero), 32'(ea == 32'h0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic expz);
    bus.aluctr = op;
    bus.a      = a;
    bus.b      = b;
    #1;
    check({name, "_out"}, bus.aluout, exp);
    check({name, "_z"},   32'(bus.iszero), 32'(expz));
  endtask

  initial begin
    bus.pcnext = 32'h40;
    bus.imm    = 32'h0;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    bus.aluctr = 4'b0000;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1 check("reset_async", bus.pc, 32'h0);
    cmp_en = 1'b1;
    tick();
    check("reset_hold", bus.pc, 32'h0);
    #2 reset = 1'b1;
    tick();
    check("first_load_pc", bus.pc, 32'h40);
    check("first_load_pcplus4", bus.pcplus4, 32'h44);

    // Reset asserted mid-cycle takes effect without a clock edge.
    bus.pcnext = 32'h80;
    tick();
    check("load_80", bus.pc, 32'h80);
    #2 reset = 1'b0;
    #1 check("reset_midcycle", bus.pc, 32'h0);
    #1 reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      bus.pcnext = bus.pcplus4;
      tick();
      check("seq_pc", bus.pc, 32'(4 * (i + 1)));
    end

    bus.pcnext = 32'hFFFF_FFFC;
    tick();
    check("pcplus4_wrap", bus.pcplus4, 32'h0);
    bus.pcnext = 32'h10;
    tick();
    bus.imm = 32'hFFFF_FFF8;
    #1 check("pcbranch_neg", bus.pcbranch, 32'h8);

    check("model_sra", ref_alu(4'b1101, 32'h8000_0000, 32'd31), 32'hFFFF_FFFF);
    check("model_slt", ref_alu(4'b0010, 32'hFFFF_FFFF, 32'd1), 32'd1);
    check("model_sll", ref_alu(4'b0001, 32'd1, 32'h21), 32'd2);

    alu_chk("add_ovf",  ALU_ADD,   32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0);
    alu_chk("sub_zero", ALU_SUB,   32'd5,         32'd5,         32'h0,         1'b1);
    alu_chk("sub_neg",  ALU_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0);
    alu_chk("slt_neg",  ALU_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    alu_chk("sltu_big", ALU_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1);
    alu_chk("slt_eq",   ALU_SLT,   32'h1234,      32'h1234,      32'd0,         1'b1);
    alu_chk("sll_mask", ALU_SLL,   32'd1,         32'h21,        32'd2,         1'b0);
    alu_chk("srl_31",   ALU_SRL,   32'h8000_0000, 32'd31,        32'd1,         1'b0);
    alu_chk("sra_31",   ALU_SRA,   32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0);
    alu_chk("and",      ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    alu_chk("or",       ALU_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    alu_chk("xor",      ALU_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    alu_chk("passb",    ALU_PASSB, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0);
    alu_chk("undef_f",  4'b1111,   32'hDEAD_BEEF, 32'h1234_5000, 32'h0,         1'b1);

    // Randomized traffic, biased toward equal operands, sign boundaries and small shifts.
    repeat (400) begin
      tick();
      bus.pcnext = $urandom;
      bus.imm    = $urandom;
      bus.aluctr = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin bus.a = $urandom; bus.b = bus.a; end
        1: begin bus.a = 32'h8000_0000 | $urandom_range(0, 3); bus.b = $urandom_range(0, 40); end
        2: begin bus.a = $urandom; bus.b = 32'hFFFF_FFFF - $urandom_range(0, 2); end
        default: begin bus.a = $urandom; bus.b = $urandom; end
      endcase
    end

    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
